board_reset_sequencer: RTL



---
 rtl/board_reset_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/board_reset_sequencer.sv
// board_reset_sequencer
//   Board bring-up sequencer.
//   - Holds the PLL in reset, then waits for a stable lock.
//   - Holds the SoC in reset for a fixed time, then releases it.
//   - A debounced KEY press in RUN gives a soft SoC reset. The PLL keeps running.
//   - Restarts from PLL reset on lock loss or on lock timeout.
//
// Ports
//   clk         in   free-running reference clock (never gated by the PLL)
//   reset       in   synchronous, active-high global reset
//   key_n       in   async push-button, active-low
//   pll_locked  in   async PLL lock indicator
//   pll_rst     out  PLL reset, active-high, high only in PLL_RST
//   soc_reset   out  SoC reset, active-high, low only in RUN (clk domain;
//                    the SoC clock domain must resynchronize it)
//   ready       out  high only in RUN
//   state       out  0=PLL_RST 1=WAIT_LOCK 2=SOC_HOLD 3=RUN
//   retry_cnt   out  PLL retries caused by lock timeout, saturates at 15
module board_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned SOC_HOLD_CYCLES     = 32,
  parameter int unsigned DEBOUNCE_CYCLES     = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       soc_reset,
  output logic       ready,
  output logic [1:0] state,
  output logic [3:0] retry_cnt
);

  localparam int PW = $clog2(PLL_RST_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(SOC_HOLD_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  // Each counter runs from 0 on state entry. The transition happens on the
  // cycle the counter holds the LAST value. So the state lasts exactly N cycles.
  localparam logic [PW-1:0] PLL_LAST     = PW'(PLL_RST_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST    = HW'(SOC_HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_SOC_HOLD  = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t cur_state, nxt_state;

  logic lock_s1, lock_s;
  logic key_s1, key_s;

  logic [PW-1:0] pll_cnt, pll_cnt_nxt;
  logic [SW-1:0] stable_cnt, stable_cnt_nxt;
  logic [TW-1:0] timeout_cnt, timeout_cnt_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic [3:0]    retry_nxt;

  logic [DW-1:0] deb_cnt;
  logic          key_db;
  logic          press_evt;

  // Two-flop synchronizers. Lock resets low and the key resets released.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_s1 <= 1'b0;
      lock_s  <= 1'b0;
      key_s1  <= 1'b1;
      key_s   <= 1'b1;
    end else begin
      lock_s1 <= pll_locked;
      lock_s  <= lock_s1;
      key_s1  <= key_n;
      key_s   <= key_s1;
    end
  end

  // Debounce. The counter runs only while the synced level differs from the
  // accepted level. Any bounce back to the accepted level clears it. So the
  // new level must hold for DEBOUNCE_CYCLES consecutive cycles to be accepted.
  // press_evt is a one-cycle pulse on an accepted 1->0 change (key pressed).
  always_ff @(posedge clk) begin
    if (reset) begin
      key_db    <= 1'b1;
      deb_cnt   <= '0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      if (key_s == key_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        key_db    <= key_s;
        deb_cnt   <= '0;
        // key_s differs from key_db here. So key_db==1 means a 1->0 change.
        press_evt <= key_db;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Next-state and counter logic.
  always_comb begin
    nxt_state       = cur_state;
    pll_cnt_nxt     = pll_cnt;
    stable_cnt_nxt  = stable_cnt;
    timeout_cnt_nxt = timeout_cnt;
    hold_cnt_nxt    = hold_cnt;
    retry_nxt       = retry_cnt;

    case (cur_state)
      S_PLL_RST: begin
        if (pll_cnt == PLL_LAST) begin
          nxt_state       = S_WAIT_LOCK;
          pll_cnt_nxt     = '0;
          stable_cnt_nxt  = '0;
          timeout_cnt_nxt = '0;
        end else begin
          pll_cnt_nxt = pll_cnt + 1'b1;
        end
      end

      S_WAIT_LOCK: begin
        // The stable check comes first. So a lock that completes on the
        // timeout cycle still wins.
        if (lock_s && (stable_cnt == STABLE_LAST)) begin
          nxt_state    = S_SOC_HOLD;
          hold_cnt_nxt = '0;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          nxt_state   = S_PLL_RST;
          pll_cnt_nxt = '0;
          if (retry_cnt != 4'd15) begin
            retry_nxt = retry_cnt + 4'd1;
          end
        end else begin
          stable_cnt_nxt  = lock_s ? (stable_cnt + 1'b1) : '0;
          timeout_cnt_nxt = timeout_cnt + 1'b1;
        end
      end

      S_SOC_HOLD: begin
        if (!lock_s) begin
          nxt_state   = S_PLL_RST;
          pll_cnt_nxt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          nxt_state = S_RUN;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end

      S_RUN: begin
        if (!lock_s) begin
          nxt_state   = S_PLL_RST;
          pll_cnt_nxt = '0;
        end else if (press_evt) begin
          nxt_state    = S_SOC_HOLD;
          hold_cnt_nxt = '0;
        end
      end

      default: begin
        nxt_state   = S_PLL_RST;
        pll_cnt_nxt = '0;
      end
    endcase
  end

  // State, counters, and outputs. Outputs decode from nxt_state, so they
  // change on the same edge that enters the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state   <= S_PLL_RST;
      pll_cnt     <= '0;
      stable_cnt  <= '0;
      timeout_cnt <= '0;
      hold_cnt    <= '0;
      retry_cnt   <= 4'd0;
      pll_rst     <= 1'b1;
      soc_reset   <= 1'b1;
      ready       <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      pll_cnt     <= pll_cnt_nxt;
      stable_cnt  <= stable_cnt_nxt;
      timeout_cnt <= timeout_cnt_nxt;
      hold_cnt    <= hold_cnt_nxt;
      retry_cnt   <= retry_nxt;
      pll_rst     <= (nxt_state == S_PLL_RST);
      soc_reset   <= (nxt_state != S_RUN);
      ready       <= (nxt_state == S_RUN);
    end
  end

  assign state = cur_state;

endmodule
